// File: rtl/dcf77_encoder.sv
// DCF77 time-code pulse generator: 59-bit minute frame, one pulse per second, minute marker at second 59.
// Optional error injection (P3 inversion, missing minute marker) is built only with DCF_ERR_INJECT_EN.
module dcf77_encoder #(
  parameter int CLK_FREQ = 500,
  parameter int LOW_ZERO = 50,
  parameter int LOW_ONE  = 100
) (
  input  logic       clk,
  input  logic       nReset,
  input  logic       enable_in,
  input  logic       load_in,
  output logic       ready_out,
  input  logic [6:0] minute_in,
  input  logic [5:0] hour_in,
  input  logic [5:0] day_in,
  input  logic [2:0] weekday_in,
  input  logic [4:0] month_in,
  input  logic [7:0] year_in,
  input  logic       cest_in,
`ifdef DCF_ERR_INJECT_EN
  input  logic       err_parity_in,
  input  logic       err_nomark_in,
`endif
  output logic       dcf_out,
  output logic [5:0] second_out,
  output logic       frame_start_out
);

  localparam int CW = $clog2(CLK_FREQ);
  localparam logic [CW-1:0] SEC_LAST = CW'(CLK_FREQ - 1);

  typedef enum logic [2:0] {IDLE, SYNC, PULSE, SPACE, MARK} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0]    sec_q, sec_d;
  logic          dcf_q, dcf_d;
  logic          fs_q, fs_d;
  logic          pend_full_q, pend_full_d;
  logic [58:0]   pend_q, pend_d;
  logic [58:0]   act_q, act_d;
  logic          start0, load_acc, cur_bit;
  logic [63:0]   act_ext;
  logic [CW-1:0] pulse_last;
  logic          par_err, nomark;

  function automatic logic [58:0] build_frame(
    input logic [6:0] mi, input logic [5:0] hr, input logic [5:0] dy,
    input logic [2:0] wd, input logic [4:0] mo, input logic [7:0] yr, input logic cest);
    build_frame = {^{dy, wd, mo, yr}, yr, mo, wd, dy, ^hr, hr, ^mi, mi,
                   1'b1, 1'b0, ~cest, cest, 17'b0};
  endfunction

`ifdef DCF_ERR_INJECT_EN
  logic par_err_q, par_err_d, nomark_q, nomark_d;
  assign par_err = par_err_q;
  assign nomark  = nomark_q;
`else
  assign par_err = 1'b0;
  assign nomark  = 1'b0;
`endif

  // Bits 59..63 pad to zero so second 59 (no-mark case) always sends a short pulse.
  always_comb begin
    act_ext     = {5'b0, act_q};
    act_ext[58] = act_q[58] ^ par_err;
    cur_bit     = act_ext[sec_q];
    pulse_last  = cur_bit ? CW'(LOW_ONE - 1) : CW'(LOW_ZERO - 1);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sec_d   = sec_q;
    start0  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        sec_d = '0;
        if (enable_in) state_d = SYNC;
      end
      SYNC, MARK: begin
        if (cnt_q == SEC_LAST) begin
          state_d = PULSE;
          cnt_d   = '0;
          sec_d   = '0;
          start0  = 1'b1;
        end else cnt_d = cnt_q + CW'(1);
      end
      PULSE: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == pulse_last) state_d = SPACE;
      end
      SPACE: begin
        if (cnt_q == SEC_LAST) begin
          cnt_d = '0;
          if (sec_q == 6'd58 && !nomark) begin
            state_d = MARK;
            sec_d   = 6'd59;
          end else if (sec_q >= 6'd59) begin
            state_d = PULSE;
            sec_d   = '0;
            start0  = 1'b1;
          end else begin
            state_d = PULSE;
            sec_d   = sec_q + 6'd1;
          end
        end else cnt_d = cnt_q + CW'(1);
      end
      default: state_d = IDLE;
    endcase
    if (!enable_in) begin
      state_d = IDLE;
      cnt_d   = '0;
      sec_d   = '0;
      start0  = 1'b0;
    end
    dcf_d = (state_d != PULSE);
    fs_d  = start0;
  end

  // A full pending buffer blocks new loads, so a load on the transfer cycle is dropped.
  always_comb begin
    load_acc    = load_in && !pend_full_q;
    pend_full_d = pend_full_q;
    pend_d      = pend_q;
    act_d       = act_q;
    if (start0 && pend_full_q) begin
      act_d       = pend_q;
      pend_full_d = 1'b0;
    end
    if (load_acc) begin
      pend_d      = build_frame(minute_in, hour_in, day_in, weekday_in, month_in, year_in, cest_in);
      pend_full_d = 1'b1;
    end
  end

`ifdef DCF_ERR_INJECT_EN
  always_comb begin
    par_err_d = par_err_q;
    nomark_d  = nomark_q;
    if (start0) begin
      par_err_d = err_parity_in;
      nomark_d  = err_nomark_in;
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      par_err_q <= 1'b0;
      nomark_q  <= 1'b0;
    end else begin
      par_err_q <= par_err_d;
      nomark_q  <= nomark_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sec_q       <= '0;
      dcf_q       <= 1'b1;
      fs_q        <= 1'b0;
      pend_full_q <= 1'b0;
      pend_q      <= '0;
      act_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sec_q       <= sec_d;
      dcf_q       <= dcf_d;
      fs_q        <= fs_d;
      pend_full_q <= pend_full_d;
      pend_q      <= pend_d;
      act_q       <= act_d;
    end
  end

  assign ready_out       = !pend_full_q;
  assign dcf_out         = dcf_q;
  assign second_out      = sec_q;
  assign frame_start_out = fs_q;

endmodule
